// File: rtl/magnetron_timer_pkg.sv
// magnetron_pkg: shared definitions for the magnetron cook timer.
//   state_t    - FSM state encoding (also driven on state_o)
//   DIGIT_W    - width of one BCD digit
//   SEC_T_MAX  - largest legal tens-of-seconds digit
//   DIGIT_MAX  - largest legal BCD digit
//   sat_digit  - clamps a raw load digit to a legal maximum
package magnetron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COOKING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] SEC_T_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d,
                                                   input logic [DIGIT_W-1:0] max_val);
    return (d > max_val) ? max_val : d;
  endfunction

endpackage

// File: rtl/magnetron_timer_if.sv
// magnetron_timer_if: control/data bundle between the on/off logic and the timer.
//   master modport : drives set/reset/clear/load/tick and the BCD load digits
//   slave modport  : the timer; returns mag_on, timer_done, remaining time, state
interface magnetron_timer_if;
  import magnetron_pkg::*;

  logic               set;
  logic               reset;
  logic               clear;
  logic               load;
  logic [DIGIT_W-1:0] ld_min_t;
  logic [DIGIT_W-1:0] ld_min_u;
  logic [DIGIT_W-1:0] ld_sec_t;
  logic [DIGIT_W-1:0] ld_sec_u;
  logic               tick;
  logic               mag_on;
  logic               timer_done;
  logic [DIGIT_W-1:0] min_t;
  logic [DIGIT_W-1:0] min_u;
  logic [DIGIT_W-1:0] sec_t;
  logic [DIGIT_W-1:0] sec_u;
  logic [1:0]         state_o;

  modport master (
    output set, reset, clear, load, ld_min_t, ld_min_u, ld_sec_t, ld_sec_u, tick,
    input  mag_on, timer_done, min_t, min_u, sec_t, sec_u, state_o
  );

  modport slave (
    input  set, reset, clear, load, ld_min_t, ld_min_u, ld_sec_t, ld_sec_u, tick,
    output mag_on, timer_done, min_t, min_u, sec_t, sec_u, state_o
  );

endinterface

// File: rtl/magnetron_timer_bcd_down_digit.sv
// bcd_down_digit: one BCD digit of a down-counter, purely combinational.
//   digit      - current digit value
//   borrow_in  - decrement request from the less significant digit
//   max_val    - value to wrap to when borrowing through zero
//   next_digit - digit after the (optional) decrement
//   borrow_out - this digit wrapped, so the next digit must decrement
module bcd_down_digit
  import magnetron_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               borrow_in,
  input  logic [DIGIT_W-1:0] max_val,
  output logic [DIGIT_W-1:0] next_digit,
  output logic               borrow_out
);

  logic at_zero;

  assign at_zero    = (digit == '0);
  assign borrow_out = borrow_in & at_zero;

  always_comb begin
    next_digit = digit;
    if (borrow_in) begin
      next_digit = at_zero ? max_val : digit - 4'd1;
    end
  end

endmodule

// File: rtl/magnetron_timer.sv
// magnetron_timer: MM:SS BCD cook timer driving the magnetron enable.
//   clk  - system clock, rising edge
//   rstn - asynchronous active-low reset
//   bus  - magnetron_timer_if.slave (start/stop/clear/load/tick in,
//          mag_on/timer_done/remaining time/state out)
// Build option: define MAGNETRON_PAUSE_RESUME_EN to make a stop during cooking
// pause with the remaining time kept; otherwise a stop zeroes the time.
//
// state   | meaning
// IDLE    | magnetron off, count may hold a loaded time
// COOKING | magnetron on, count decrements on each tick
// PAUSED  | stopped mid-cook, count retained (pause/resume build only)
// DONE    | one-cycle terminal state, timer_done high
module magnetron_timer
  import magnetron_pkg::*;
(
  input logic             clk,
  input logic             rstn,
  magnetron_timer_if.slave bus
);

  state_t             state_q;
  logic               mag_on_q;
  logic               timer_done_q;
  logic [DIGIT_W-1:0] min_t_q, min_u_q, sec_t_q, sec_u_q;

  logic [DIGIT_W-1:0] dec_min_t, dec_min_u, dec_sec_t, dec_sec_u;
  logic               b_sec_u, b_sec_t, b_min_u, b_min_t;
  logic               cnt_zero;
  logic               cnt_one;
  logic               can_edit;

  bcd_down_digit u_sec_u (.digit(sec_u_q), .borrow_in(1'b1),   .max_val(DIGIT_MAX),
                          .next_digit(dec_sec_u), .borrow_out(b_sec_u));
  bcd_down_digit u_sec_t (.digit(sec_t_q), .borrow_in(b_sec_u), .max_val(SEC_T_MAX),
                          .next_digit(dec_sec_t), .borrow_out(b_sec_t));
  bcd_down_digit u_min_u (.digit(min_u_q), .borrow_in(b_sec_t), .max_val(DIGIT_MAX),
                          .next_digit(dec_min_u), .borrow_out(b_min_u));
  bcd_down_digit u_min_t (.digit(min_t_q), .borrow_in(b_min_u), .max_val(DIGIT_MAX),
                          .next_digit(dec_min_t), .borrow_out(b_min_t));

  // The chain always requests a decrement, so a borrow out of the top digit
  // means every digit is zero.
  assign cnt_zero = b_min_t;
  assign cnt_one  = ({min_t_q, min_u_q, sec_t_q} == '0) && (sec_u_q == 4'd1);
  assign can_edit = (state_q == ST_IDLE) || (state_q == ST_PAUSED);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      mag_on_q     <= 1'b0;
      timer_done_q <= 1'b0;
      min_t_q      <= '0;
      min_u_q      <= '0;
      sec_t_q      <= '0;
      sec_u_q      <= '0;
    end else begin
      timer_done_q <= 1'b0;
      if (bus.clear) begin
        state_q  <= ST_IDLE;
        mag_on_q <= 1'b0;
        min_t_q  <= '0;
        min_u_q  <= '0;
        sec_t_q  <= '0;
        sec_u_q  <= '0;
      end else if (state_q == ST_DONE) begin
        // DONE is a single-cycle state whatever else is requested.
        state_q <= ST_IDLE;
      end else if (bus.reset) begin
        // A stop outside COOKING is a no-op but still masks load/set/tick.
        if (state_q == ST_COOKING) begin
          mag_on_q <= 1'b0;
`ifdef MAGNETRON_PAUSE_RESUME_EN
          state_q  <= ST_PAUSED;
`else
          state_q  <= ST_IDLE;
          min_t_q  <= '0;
          min_u_q  <= '0;
          sec_t_q  <= '0;
          sec_u_q  <= '0;
`endif
        end
      end else if (bus.load && can_edit) begin
        min_t_q <= sat_digit(bus.ld_min_t, DIGIT_MAX);
        min_u_q <= sat_digit(bus.ld_min_u, DIGIT_MAX);
        sec_t_q <= sat_digit(bus.ld_sec_t, SEC_T_MAX);
        sec_u_q <= sat_digit(bus.ld_sec_u, DIGIT_MAX);
      end else if (bus.set && can_edit && !bus.load) begin
        if (!cnt_zero) begin
          state_q  <= ST_COOKING;
          mag_on_q <= 1'b1;
        end
      end else if (bus.tick && (state_q == ST_COOKING)) begin
        if (cnt_one) begin
          state_q      <= ST_DONE;
          mag_on_q     <= 1'b0;
          timer_done_q <= 1'b1;
        end
        min_t_q <= dec_min_t;
        min_u_q <= dec_min_u;
        sec_t_q <= dec_sec_t;
        sec_u_q <= dec_sec_u;
      end
    end
  end

  assign bus.state_o    = state_q;
  assign bus.mag_on     = mag_on_q;
  assign bus.timer_done = timer_done_q;
  assign bus.min_t      = min_t_q;
  assign bus.min_u      = min_u_q;
  assign bus.sec_t      = sec_t_q;
  assign bus.sec_u      = sec_u_q;

endmodule

// File: tb/tb_magnetron_timer.sv
// tb_magnetron_timer: directed bench for magnetron_timer. Each step pushes the
// expected state/mag_on/timer_done/count to a scoreboard queue, clocks the DUT
// and pops the entry to compare against the registered outputs.
module tb_magnetron_timer;
  import magnetron_pkg::*;

  typedef struct packed {
    logic [1:0]  st;
    logic        mag;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rstn;
  magnetron_timer_if bus();

  magnetron_timer dut (.clk(clk), .rstn(rstn), .bus(bus));

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  localparam logic [1:0] I = 2'd0, C = 2'd1, P = 2'd2, D = 2'd3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [1:0] s, input logic m,
                      input logic d, input logic [15:0] c);
    exp_t e;
    e.st = s; e.mag = m; e.done = d; e.cnt = c;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    exp_t        e;
    string       t;
    logic [15:0] cnt;
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    cnt = {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u};
    total++;
    assert (bus.state_o === e.st) else begin
      bad++; $error("FAIL %s state got=%0d want=%0d", t, bus.state_o, e.st);
    end
    total++;
    assert (bus.mag_on === e.mag) else begin
      bad++; $error("FAIL %s mag_on got=%b want=%b", t, bus.mag_on, e.mag);
    end
    total++;
    assert (bus.timer_done === e.done) else begin
      bad++; $error("FAIL %s timer_done got=%b want=%b", t, bus.timer_done, e.done);
    end
    total++;
    assert (cnt === e.cnt) else begin
      bad++; $error("FAIL %s count got=%h want=%h", t, cnt, e.cnt);
    end
  endtask

  task automatic idle_inputs();
    bus.set = 1'b0; bus.reset = 1'b0; bus.clear = 1'b0;
    bus.load = 1'b0; bus.tick = 1'b0;
  endtask

  // One clock with the inputs currently driven, then compare.
  task automatic cyc(input string tag, input logic [1:0] s, input logic m,
                     input logic d, input logic [15:0] c);
    push(tag, s, m, d, c);
    @(posedge clk);
    #1;
    idle_inputs();
    check_pop();
  endtask

  task automatic ld(input logic [3:0] a, input logic [3:0] b,
                    input logic [3:0] c, input logic [3:0] d);
    bus.ld_min_t = a; bus.ld_min_u = b; bus.ld_sec_t = c; bus.ld_sec_u = d;
    bus.load = 1'b1;
  endtask

  initial begin
    idle_inputs();
    ld(4'd0, 4'd0, 4'd0, 4'd0);
    bus.load = 1'b0;
    rstn = 1'b0;
    #3;
    push("por", I, 1'b0, 1'b0, 16'h0000);
    check_pop();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic countdown to done
    ld(4'd0, 4'd0, 4'd0, 4'd3);   cyc("ld3",    I, 0, 0, 16'h0003);
    bus.set = 1;                  cyc("set3",   C, 1, 0, 16'h0003);
    bus.tick = 1;                 cyc("t3a",    C, 1, 0, 16'h0002);
    bus.tick = 1;                 cyc("t3b",    C, 1, 0, 16'h0001);
    bus.tick = 1;                 cyc("t3c",    D, 0, 1, 16'h0000);
    cyc("post3", I, 0, 0, 16'h0000);

    // Minute borrow chain
    ld(4'd1, 4'd0, 4'd0, 4'd0);   cyc("ld1000", I, 0, 0, 16'h1000);
    bus.set = 1;                  cyc("set1000",C, 1, 0, 16'h1000);
    bus.tick = 1;                 cyc("t0959",  C, 1, 0, 16'h0959);
    bus.tick = 1;                 cyc("t0958",  C, 1, 0, 16'h0958);
    bus.clear = 1;                cyc("clr1",   I, 0, 0, 16'h0000);

    // Tick on the start cycle does not decrement
    ld(4'd0, 4'd0, 4'd0, 4'd2);   cyc("ld2",    I, 0, 0, 16'h0002);
    bus.set = 1; bus.tick = 1;    cyc("settick",C, 1, 0, 16'h0002);
    bus.clear = 1; bus.tick = 1;  cyc("clr2",   I, 0, 0, 16'h0000);

    // Stop mid-cook
    ld(4'd0, 4'd0, 4'd0, 4'd5);   cyc("ld5",    I, 0, 0, 16'h0005);
    bus.set = 1;                  cyc("set5",   C, 1, 0, 16'h0005);
    bus.tick = 1;                 cyc("t5a",    C, 1, 0, 16'h0004);
    bus.tick = 1;                 cyc("t5b",    C, 1, 0, 16'h0003);
`ifdef MAGNETRON_PAUSE_RESUME_EN
    bus.reset = 1; bus.tick = 1;  cyc("stop5",  P, 0, 0, 16'h0003);
    for (int k = 0; k < 3; k++) begin
      bus.tick = 1;               cyc("pz",     P, 0, 0, 16'h0003);
    end
    bus.set = 1;                  cyc("resume", C, 1, 0, 16'h0003);
    bus.tick = 1;                 cyc("r2",     C, 1, 0, 16'h0002);
    bus.tick = 1;                 cyc("r1",     C, 1, 0, 16'h0001);
    bus.tick = 1;                 cyc("r0",     D, 0, 1, 16'h0000);
    cyc("rpost", I, 0, 0, 16'h0000);
`else
    bus.reset = 1; bus.tick = 1;  cyc("stop5",  I, 0, 0, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      bus.tick = 1;               cyc("sz",     I, 0, 0, 16'h0000);
    end
`endif

    // Start with zero count, set+reset, minute borrow, load while cooking
    bus.set = 1;                  cyc("set0",   I, 0, 0, 16'h0000);
    ld(4'd0, 4'd1, 4'd0, 4'd0);   cyc("ld0100", I, 0, 0, 16'h0100);
    bus.set = 1; bus.reset = 1;   cyc("setrst", I, 0, 0, 16'h0100);
    ld(4'd0, 4'd2, 4'd0, 4'd0); bus.set = 1;
                                  cyc("ldset",  I, 0, 0, 16'h0200);
    bus.set = 1;                  cyc("set0200",C, 1, 0, 16'h0200);
    bus.tick = 1;                 cyc("t0159",  C, 1, 0, 16'h0159);
    ld(4'd9, 4'd9, 4'd5, 4'd9);   cyc("ldcook", C, 1, 0, 16'h0159);
`ifdef MAGNETRON_PAUSE_RESUME_EN
    bus.reset = 1;                cyc("stop2",  P, 0, 0, 16'h0159);
    ld(4'd0, 4'd0, 4'd4, 4'd0);   cyc("ldpause",P, 0, 0, 16'h0040);
`else
    bus.reset = 1;                cyc("stop2",  I, 0, 0, 16'h0000);
`endif
    bus.clear = 1; bus.load = 1;  cyc("clrld",  I, 0, 0, 16'h0000);

    // Load saturation
    ld(4'hF, 4'hF, 4'hF, 4'hF);   cyc("satF",   I, 0, 0, 16'h9959);
    ld(4'd0, 4'hA, 4'd7, 4'd3);   cyc("sat2",   I, 0, 0, 16'h0953);

    // Async reset while cooking
    ld(4'd0, 4'd0, 4'd1, 4'd0);   cyc("ld0010", I, 0, 0, 16'h0010);
    bus.set = 1;                  cyc("set10",  C, 1, 0, 16'h0010);
    bus.tick = 1;                 cyc("t0009",  C, 1, 0, 16'h0009);
    rstn = 1'b0;
    #2;
    push("arst", I, 1'b0, 1'b0, 16'h0000);
    check_pop();
    #1;
    rstn = 1'b1;
    bus.tick = 1;                 cyc("arel",   I, 0, 0, 16'h0000);
    bus.set = 1;                  cyc("arset",  I, 0, 0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/magnetron_timer.md
MAGNETRON_TIMER -- requirements
Module: magnetron_timer

Interface
REQ-001 The block SHALL have one clock, one reset, and the ports listed in REQ-002 to REQ-013, with these names, directions and widths.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 set  input  1  active-high start request from the on/off logic.
REQ-005 reset  input  1  active-high stop request from the on/off logic (door open, stop, clear or done).
REQ-006 clear  input  1  active-high; zeroes the count.
REQ-007 load  input  1  active-high single-cycle strobe; captures the load digits.
REQ-008 ld_min_t, ld_min_u, ld_sec_t, ld_sec_u  input  4 each  BCD load value MM:SS.
REQ-009 tick  input  1  single-cycle 1 Hz enable.
REQ-010 mag_on  output  1  magnetron drive; high only in state COOKING.
REQ-011 timer_done  output  1  single-cycle pulse when the count expires.
REQ-012 min_t, min_u, sec_t, sec_u  output  4 each  current remaining time in BCD, registered.
REQ-013 state_o  output  2  current state encoding: IDLE=0, COOKING=1, PAUSED=2, DONE=3.

Function
REQ-014 The FSM SHALL have states IDLE, COOKING, PAUSED and DONE, and all outputs SHALL be registered.
REQ-015 Input priority each cycle SHALL be clear > reset > load > set > tick.
REQ-016 clear in any state SHALL zero the count and enter IDLE on the next edge.
REQ-017 load in IDLE or PAUSED SHALL capture the load digits on the next edge; load in COOKING or DONE SHALL be ignored.
REQ-018 Load SHALL saturate digits: any digit above 9 becomes 9, and ld_sec_t above 5 becomes 5.
REQ-019 set in IDLE or PAUSED with a nonzero count SHALL enter COOKING on the next edge, with mag_on=1 in that same cycle.
REQ-020 set with count 00:00 SHALL be ignored.
REQ-021 set in the same cycle as load SHALL be ignored.
REQ-022 In COOKING, each tick SHALL decrement MM:SS by one second using BCD borrow: sec_u 0->9, sec_t 0->5, min_u 0->9, min_t decrements.
REQ-023 A tick in the same cycle that COOKING is entered SHALL NOT decrement.
REQ-024 A tick in COOKING when the count is 00:01 SHALL produce 00:00, enter DONE, set mag_on=0 and set timer_done=1, all on the same edge.
REQ-025 DONE SHALL last exactly one cycle and then enter IDLE; timer_done SHALL be high only during DONE.
REQ-026 reset in COOKING SHALL deassert mag_on on the next edge; the count SHALL NOT decrement even if tick is high.
REQ-027 The target state after reset in COOKING SHALL be as defined in REQ-033 and REQ-034.
REQ-028 reset in IDLE, PAUSED or DONE SHALL NOT change the state.
REQ-029 Simultaneous set and reset SHALL act as reset (no start).
REQ-030 Any state/input combination not listed above SHALL leave state and count unchanged.

Reset
REQ-031 While rstn=0, the block SHALL hold state IDLE, count 00:00, mag_on=0 and timer_done=0, independent of clk.
REQ-032 Deassertion of rstn mid-COOKING SHALL resume from IDLE with count 00:00.

Configuration
REQ-033 With macro MAGNETRON_PAUSE_RESUME_EN defined, reset in COOKING SHALL enter PAUSED with the count retained, and a later set SHALL resume counting from the retained value.
REQ-034 Without MAGNETRON_PAUSE_RESUME_EN, reset in COOKING SHALL zero the count and enter IDLE; the block SHALL never enter PAUSED, and state_o=2 SHALL be unreachable.

Structure
REQ-035 Package magnetron_pkg SHALL hold:
- the state encoding;
- BCD digit width (4);
- constants SEC_T_MAX=5 and DIGIT_MAX=9.
REQ-036 One sub-module, bcd_down_digit, SHALL be instantiated four times.
- Inputs: digit, borrow_in, max value.
- Outputs: next digit, borrow_out.
- Purely combinational.

Verification
REQ-037 Load 00:03, set, then 3 ticks -> mag_on high for 3 ticks; count goes 00:02, 00:01, 00:00; timer_done pulses 1 cycle on the third tick; state ends IDLE.
REQ-038 Load 10:00, set, 1 tick -> count 09:59; a further tick -> 09:58.
REQ-039 Load 00:05, set, 2 ticks, reset, then 3 ticks:
- With the macro: count 00:03, state PAUSED, mag_on 0; set then 3 ticks -> done.
- Without the macro: count 00:00, state IDLE.
REQ-040 Count 00:00, set -> state stays IDLE, mag_on 0; simultaneous set+reset with count 01:00 -> no start.
REQ-041 Load digits F:F:F:F -> count reads 99:59.
REQ-042 rstn low mid-COOKING -> mag_on 0 immediately; state IDLE, count 00:00.
REQ-043 load during COOKING -> ignored.
